// File: rtl/burst_initiator.sv
// Burst test initiator: writes a seed+index pattern over an AXI-like channel set,
// reads it back, and counts response and data errors.
module burst_initiator #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [7:0]        cfg_len,
  input  logic [DATA_W-1:0] cfg_seed,
  input  logic [1:0]        cfg_mode,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_cnt,
  output logic              pass,
  output logic              aw_valid,
  output logic [ADDR_W-1:0] aw_addr,
  output logic [7:0]        aw_len,
  input  logic              aw_ready,
  output logic              w_valid,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last,
  input  logic              w_ready,
  input  logic              b_valid,
  input  logic [1:0]        b_resp,
  output logic              b_ready,
  output logic              ar_valid,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [7:0]        ar_len,
  input  logic              ar_ready,
  input  logic              r_valid,
  input  logic [DATA_W-1:0] r_data,
  input  logic              r_last,
  input  logic [1:0]        r_resp,
  output logic              r_ready
);

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    AR,
    R,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [DATA_W-1:0] seed_q;
  logic [1:0]        mode_q;
  logic [7:0]        w_idx;
  logic [7:0]        r_idx;
  logic              r_over;

  logic              accept;
  logic              w_fire;
  logic              b_fire;
  logic              r_fire;
  logic              r_data_bad;
  logic              r_missing_last;
  logic              r_len_mismatch;
  logic              r_beat_err;
  logic              err_inc;
  logic [15:0]       err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Moore outputs only: every handshake signal depends on state alone, so at most
  // one channel is ever active and reset clears them all at once.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (cfg_mode == 2'd2) ? AR : AW;
        end
      end
      AW: begin
        busy     = 1'b1;
        aw_valid = 1'b1;
        if (aw_ready) begin
          state_nxt = W;
        end
      end
      W: begin
        busy    = 1'b1;
        w_valid = 1'b1;
        if (w_ready && (w_idx == len_q)) begin
          state_nxt = B;
        end
      end
      B: begin
        busy    = 1'b1;
        b_ready = 1'b1;
        if (b_valid) begin
          state_nxt = (mode_q == 2'd1) ? DONE : AR;
        end
      end
      AR: begin
        busy     = 1'b1;
        ar_valid = 1'b1;
        if (ar_ready) begin
          state_nxt = R;
        end
      end
      R: begin
        busy    = 1'b1;
        r_ready = 1'b1;
        if (r_valid && r_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept  = (state == IDLE) && start;
  assign w_fire  = (state == W) && w_ready;
  assign b_fire  = (state == B) && b_valid;
  assign r_fire  = (state == R) && r_valid;

  assign aw_addr = addr_q;
  assign aw_len  = len_q;
  assign ar_addr = addr_q;
  assign ar_len  = len_q;
  assign w_data  = seed_q + DATA_W'(w_idx);
  assign w_last  = (state == W) && (w_idx == len_q);

  // r_over makes the missing-r_last error count once even if beats keep coming.
  assign r_data_bad     = (r_data != (seed_q + DATA_W'(r_idx)));
  assign r_missing_last = !r_last && (r_idx == len_q) && !r_over;
  assign r_len_mismatch = r_last && (r_idx != len_q);
  assign r_beat_err     = (r_resp != 2'b00) || r_data_bad || r_len_mismatch || r_missing_last;

  assign err_inc = (b_fire && (b_resp != 2'b00)) || (r_fire && r_beat_err);
  assign err_nxt = (err_inc && (err_cnt != 16'hFFFF)) ? (err_cnt + 16'd1) : err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      mode_q  <= '0;
      w_idx   <= '0;
      r_idx   <= '0;
      r_over  <= 1'b0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= cfg_addr;
        len_q   <= cfg_len;
        seed_q  <= cfg_seed;
        mode_q  <= cfg_mode;
        w_idx   <= '0;
        r_idx   <= '0;
        r_over  <= 1'b0;
        err_cnt <= '0;
        pass    <= 1'b0;
      end else begin
        err_cnt <= err_nxt;
        if (w_fire) begin
          w_idx <= w_idx + 8'd1;
        end
        if (r_fire) begin
          r_idx <= r_idx + 8'd1;
          if (r_missing_last) begin
            r_over <= 1'b1;
          end
        end
        // Sampled on entry to DONE so pass is already valid alongside the done pulse.
        if ((state_nxt == DONE) && (state != DONE)) begin
          pass <= (err_nxt == 16'd0);
        end
      end
    end
  end

endmodule

// File: doc/burst_initiator.md
BURST_INITIATOR -- requirements
Module: burst_initiator

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to launch a test.
REQ-006 SHALL have port cfg_addr, input, ADDR_W bits: burst start address.
REQ-007 SHALL have port cfg_len, input, 8 bits: beats-1.
REQ-008 SHALL have port cfg_seed, input, DATA_W bits: pattern base value.
REQ-009 SHALL have port cfg_mode, input, 2 bits: 0 = write then read, 1 = write only, 2 = read only, 3 = treated as 0.
REQ-010 SHALL have port busy, output, 1 bit: test in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port err_cnt, output, 16 bits: error count.
REQ-013 SHALL have port pass, output, 1 bit: last test ended with err_cnt==0.
REQ-014 SHALL have output ports aw_valid (1), aw_addr (ADDR_W), aw_len (8) and input port aw_ready (1): write-address channel.
REQ-015 SHALL have output ports w_valid (1), w_data (DATA_W), w_last (1) and input port w_ready (1): write-data channel.
REQ-016 SHALL have input ports b_valid (1), b_resp (2) and output port b_ready (1): write-response channel.
REQ-017 SHALL have output ports ar_valid (1), ar_addr (ADDR_W), ar_len (8) and input port ar_ready (1): read-address channel.
REQ-018 SHALL have input ports r_valid (1), r_data (DATA_W), r_last (1), r_resp (2) and output port r_ready (1): read-data channel.

Function
REQ-019 SHALL implement FSM states IDLE, AW, W, B, AR, R, DONE.
REQ-020 SHALL accept start only in IDLE, ignore it in every other state, and at acceptance latch cfg_addr, cfg_len, cfg_seed and cfg_mode, clear err_cnt and pass, and raise busy.
REQ-021 SHALL go from IDLE to AW for modes 0/1/3 and to AR for mode 2, in the cycle after start is accepted.
REQ-022 SHALL drive aw_valid=1 in AW with aw_addr/aw_len held stable until aw_valid&&aw_ready, then go to W in the next cycle.
REQ-023 SHALL drive w_valid=1 in W with w_data = seed+i (i = beat index 0..len, modulo 2^DATA_W) and w_last=1 only when i==len.
REQ-024 SHALL advance i only on w_valid&&w_ready, hold w_data stable while stalled, and go to B after the last beat.
REQ-025 SHALL drive b_ready=1 in B and, on b_valid, increment err_cnt if b_resp!=0, then go to AR (modes 0/3) or DONE (mode 1).
REQ-026 SHALL drive ar_valid=1 in AR with ar_addr/ar_len held stable until ar_valid&&ar_ready, then go to R.
REQ-027 SHALL drive r_ready=1 in R and, per beat j accepted on r_valid&&r_ready: count an error if r_resp!=0; otherwise count an error if r_data != seed+j.
REQ-028 SHALL also, on the beat with r_last=1, count one extra error if j!=len, then go to DONE.
REQ-029 SHALL, if j reaches len without r_last, count one error and keep accepting beats until r_last.
REQ-030 SHALL in DONE assert done for exactly one cycle, set pass=(err_cnt==0), deassert busy, and return to IDLE.
REQ-031 SHALL saturate err_cnt at 16'hFFFF and allow at most one increment per cycle per channel event.
REQ-032 SHALL hold err_cnt and pass after DONE until the next accepted start.
REQ-033 SHALL never assert more than one of aw_valid, w_valid, b_ready, ar_valid, r_ready in the same cycle.
REQ-034 SHALL treat cfg_len=0 as a single-beat burst, with w_last asserted on the only beat.

Reset
REQ-035 SHALL, on rst asserted at any time (including mid-burst), immediately drive all valid/ready outputs, busy, done, pass and err_cnt to 0, and clear the FSM to IDLE and the beat counters to 0.
REQ-036 SHALL NOT accept start while rst is high.

Verification
REQ-037 SHALL cover: responder with 2-cycle latency, addr=0x100, len=3, seed=100, mode 0 -> W data 100..103, w_last on beat 4, R data matches, done pulse, err_cnt=0, pass=1.
REQ-038 SHALL cover: w_ready/r_ready partner stalls randomly throttled, len=7, seed=0xFFFFFFFE -> data 0xFFFFFFFE,0xFFFFFFFF,0,1..5 (wrap), payload held during stalls, pass=1.
REQ-039 SHALL cover: read-only of out-of-range addr 0xFFFFF000, len=0, responder r_resp=2 -> err_cnt=1, pass=0.
REQ-040 SHALL cover: responder corrupts beat 2 of a 4-beat read -> err_cnt=1; responder asserts r_last on beat 3 of 4 -> err_cnt=1.
REQ-041 SHALL cover: rst pulsed mid-W phase -> all outputs 0 asynchronously; a subsequent start runs cleanly to pass=1.
REQ-042 SHALL cover: start pulsed while busy -> ignored, config unchanged, a single done pulse produced.
